sdram_burst_arbiter: RTL and testbench
======================================

// Module: sdram_burst_arbiter
// PURPOSE
//  Shares one Avalon-MM burst SDRAM master port (HPS FPGA-to-SDRAM) between two bidirectional requesters:
//  port A (frame writer/reader) and port B (HDR merge reader/writer).
//  Round-robin per command. Write bursts lock the grant until their last beat.
//  A tag FIFO routes read-return beats back to the requester that issued the read.
// PARAMETERS
//  WIDTH_ADDR    29  SDRAM word address width
//  WIDTH_DATA    64  data width
//  WIDTH_BE       8  byteenable width (WIDTH_DATA/8)
//  MAX_RD_OUTST   4  max read bursts in flight (tag FIFO depth, power of 2)
// PORTS
//  clk              in   1           system clock
//  reset_n          in   1           async active-low reset
//  x_address        in   WIDTH_ADDR  requester x (x = a, b) command address
//  x_burstcount     in   8           requester burst length
//  x_read           in   1           read request
//  x_write          in   1           write request / write beat
//  x_writedata      in   WIDTH_DATA  write data
//  x_byteenable     in   WIDTH_BE    byte enables
//  x_waitrequest    out  1           stall to requester
//  x_readdata       out  WIDTH_DATA  read data (shared bus, qualify with valid)
//  x_readdatavalid  out  1           read beat for this requester
//  m_address        out  WIDTH_ADDR  master address
//  m_burstcount     out  8           master burst length
//  m_read           out  1           master read
//  m_write          out  1           master write
//  m_writedata      out  WIDTH_DATA  master write data
//  m_byteenable     out  WIDTH_BE    master byte enables
//  m_waitrequest    in   1           slave stall
//  m_readdata       in   WIDTH_DATA  slave read data
//  m_readdatavalid  in   1           slave read beat
//  rd_outstanding   out  3           read bursts in flight (0..MAX_RD_OUTST)
//  err_orphan       out  1           sticky: readdatavalid received with tag FIFO empty
// BEHAVIOUR
//  Reset: FSM=IDLE, last_grant=B (A wins first tie), tag FIFO empty, beat counters 0.
//   Reset values: err_orphan=0, m_read/m_write=0, m_address/burstcount/writedata/byteenable=0,
//   a/b_waitrequest=1, a/b_readdatavalid=0.
//  Request of x = x_write | (x_read & ~fifo_full). x_read with x_write both high: write served, read ignored.
//  FSM states:
//   IDLE: winner picked combinationally.
//     - One requester: it wins. Both: the port != last_grant wins.
//     - Winner's command goes to the master in the same cycle (zero added latency).
//     - Loser, and any x with only a blocked read, sees waitrequest=1.
//     - On accept (m_waitrequest=0): last_grant<=winner.
//       . Read: push {winner, burstcount} into tag FIFO; stay IDLE.
//       . Write, burstcount<=1: stay IDLE.
//       . Write, burstcount>1: wr_left<=burstcount-1; go WR_BURST.
//     - Not accepted: owner<=winner; go LOCK.
//   LOCK: owner's command held on master; other port stalled.
//     - On accept: same actions as IDLE accept, using owner.
//   WR_BURST: owner fixed; master mirrors owner signals.
//     - m_write follows owner x_write; idle beats are allowed.
//     - Each accepted beat (m_write & ~m_waitrequest) decrements wr_left.
//     - wr_left reaches 0: go IDLE.
//     - Non-owner waitrequest=1 throughout.
//  x_waitrequest (owner/winner) = m_waitrequest; master outputs = 0 when no port is driving.
//  burstcount=0 is treated as 1 for all counting.
//  Read return:
//   - Head tag selects destination; x_readdata = m_readdata for both ports.
//   - Only the head port gets readdatavalid.
//   - rd_left loads from head burstcount on the first beat and counts down.
//   - Last beat pops the FIFO. Back-to-back bursts from different ports switch with no gap.
//  fifo_full = (rd_outstanding == MAX_RD_OUTST), from registered count.
//   - A pop in the same cycle does NOT unblock a push.
//   - Push and pop in the same cycle leave the count unchanged.
//  m_readdatavalid with FIFO empty: dropped (no x_readdatavalid), err_orphan<=1 until reset.
//  Reset mid-burst: all state cleared immediately; in-flight reads are abandoned.
// TESTING
//  1. A read burstcount=4 at 0x100, slave returns 4 beats -> a_readdatavalid x4, b_readdatavalid=0, rd_outstanding 1->0.
//  2. A and B write, burstcount=8 each, same cycle -> A's 8 beats, then B's 8 beats; no B beat interleaved; b_waitrequest=1 during A.
//  3. A read bc=2 then B read bc=3, returns back-to-back -> 2 beats to A then 3 to B; valids cycle-exact.
//  4. Issue 5 reads with MAX_RD_OUTST=4, no returns -> 5th stalled (waitrequest=1), rd_outstanding=4; 5th accepted cycle after first burst's last beat.
//  5. m_waitrequest=1 for 3 cycles on A's command while B requests -> master holds A's address/command stable; B granted after A accepted.
//  6. Assert reset_n=0 mid write burst (beat 3 of 8), release, inject stray m_readdatavalid -> outputs at reset values; err_orphan=1; no x_readdatavalid.

Source files
------------

// File: rtl/sdram_burst_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_burst_arbiter
//
// Purpose:
//   Shares one Avalon-MM burst master port (HPS FPGA-to-SDRAM) between two
//   bidirectional requesters: port A (frame writer/reader) and port B (HDR
//   merge reader/writer). Arbitration is round-robin per command. A write
//   burst holds the grant until its last beat. Read commands push a tag
//   {port, burstcount} into a small FIFO, and that FIFO steers the returning
//   read beats back to the requester that issued the read.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   a_* / b_*                    requester slave interfaces (address,
//                                burstcount, read, write, writedata,
//                                byteenable in; waitrequest, readdata,
//                                readdatavalid out)
//   m_*                          shared master interface towards the SDRAM
//   rd_outstanding               read bursts currently in flight
//   err_orphan                   sticky: read beat arrived with no tag queued
// -----------------------------------------------------------------------------
module sdram_burst_arbiter #(
    parameter int WIDTH_ADDR   = 29,
    parameter int WIDTH_DATA   = 64,
    parameter int WIDTH_BE     = 8,
    parameter int MAX_RD_OUTST = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,

    input  logic [WIDTH_ADDR-1:0]             a_address,
    input  logic [7:0]                        a_burstcount,
    input  logic                              a_read,
    input  logic                              a_write,
    input  logic [WIDTH_DATA-1:0]             a_writedata,
    input  logic [WIDTH_BE-1:0]               a_byteenable,
    output logic                              a_waitrequest,
    output logic [WIDTH_DATA-1:0]             a_readdata,
    output logic                              a_readdatavalid,

    input  logic [WIDTH_ADDR-1:0]             b_address,
    input  logic [7:0]                        b_burstcount,
    input  logic                              b_read,
    input  logic                              b_write,
    input  logic [WIDTH_DATA-1:0]             b_writedata,
    input  logic [WIDTH_BE-1:0]               b_byteenable,
    output logic                              b_waitrequest,
    output logic [WIDTH_DATA-1:0]             b_readdata,
    output logic                              b_readdatavalid,

    output logic [WIDTH_ADDR-1:0]             m_address,
    output logic [7:0]                        m_burstcount,
    output logic                              m_read,
    output logic                              m_write,
    output logic [WIDTH_DATA-1:0]             m_writedata,
    output logic [WIDTH_BE-1:0]               m_byteenable,
    input  logic                              m_waitrequest,
    input  logic [WIDTH_DATA-1:0]             m_readdata,
    input  logic                              m_readdatavalid,

    output logic [$clog2(MAX_RD_OUTST):0]     rd_outstanding,
    output logic                              err_orphan
);

    localparam int PW = (MAX_RD_OUTST > 1) ? $clog2(MAX_RD_OUTST) : 1;
    localparam int CW = $clog2(MAX_RD_OUTST) + 1;

    localparam logic P_A = 1'b0;
    localparam logic P_B = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOCK     = 2'd1,
        S_WR_BURST = 2'd2
    } state_t;

    state_t            r_state, w_state_next;
    logic              r_last_grant, w_last_grant_next;
    logic              r_owner, w_owner_next;
    logic [7:0]        r_wr_left, w_wr_left_next;

    // tag FIFO
    logic              r_tag_port [MAX_RD_OUTST];
    logic [7:0]        r_tag_bc   [MAX_RD_OUTST];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_cnt;
    logic [7:0]        r_rd_left;
    logic              r_err_orphan;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_req_a, w_req_b;
    logic              w_drive;
    logic              w_sel;
    logic              w_push;
    logic              w_pop;
    logic [7:0]        w_push_bc;

    logic [WIDTH_ADDR-1:0] w_s_addr;
    logic [7:0]            w_s_bc;
    logic [7:0]            w_s_bc_eff;
    logic                  w_s_read;
    logic                  w_s_write;
    logic [WIDTH_DATA-1:0] w_s_wdata;
    logic [WIDTH_BE-1:0]   w_s_be;

    logic              w_head_port;
    logic [7:0]        w_head_bc;
    logic [7:0]        w_rd_rem;
    logic              w_rv;

    // fifo_full comes from the registered count, so a pop in the same cycle
    // never opens room for a push until the following cycle.
    assign w_fifo_full  = (r_cnt == CW'(MAX_RD_OUTST));
    assign w_fifo_empty = (r_cnt == '0);

    assign w_req_a = a_write | (a_read & ~w_fifo_full);
    assign w_req_b = b_write | (b_read & ~w_fifo_full);

    // -------------------------------------------------------------------------
    // Grant selection, master mux, FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_owner_next      = r_owner;
        w_wr_left_next    = r_wr_left;
        w_drive           = 1'b0;
        w_sel             = r_owner;
        w_push            = 1'b0;
        w_push_bc         = 8'd0;
        m_address         = '0;
        m_burstcount      = '0;
        m_read            = 1'b0;
        m_write           = 1'b0;
        m_writedata       = '0;
        m_byteenable      = '0;
        a_waitrequest     = 1'b1;
        b_waitrequest     = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_drive = w_req_a | w_req_b;
                if (w_req_a && w_req_b) begin
                    w_sel = ~r_last_grant;
                end else if (w_req_a) begin
                    w_sel = P_A;
                end else begin
                    w_sel = P_B;
                end
            end
            S_LOCK, S_WR_BURST: begin
                w_drive = 1'b1;
                w_sel   = r_owner;
            end
            default: begin
                w_drive = 1'b0;
            end
        endcase

        // Outputs stay at their idle values for as long as reset is held.
        w_drive = w_drive & reset_n;

        w_s_addr   = (w_sel == P_B) ? b_address    : a_address;
        w_s_bc     = (w_sel == P_B) ? b_burstcount : a_burstcount;
        w_s_read   = (w_sel == P_B) ? b_read       : a_read;
        w_s_write  = (w_sel == P_B) ? b_write      : a_write;
        w_s_wdata  = (w_sel == P_B) ? b_writedata  : a_writedata;
        w_s_be     = (w_sel == P_B) ? b_byteenable : a_byteenable;
        w_s_bc_eff = (w_s_bc == 8'd0) ? 8'd1 : w_s_bc;

        if (w_drive) begin
            m_address    = w_s_addr;
            m_burstcount = w_s_bc;
            m_writedata  = w_s_wdata;
            m_byteenable = w_s_be;
            m_write      = w_s_write;
            // write wins when both strobes are high; no reads inside a burst
            m_read       = w_s_read & ~w_s_write & (r_state != S_WR_BURST);
            if (w_sel == P_B) begin
                b_waitrequest = m_waitrequest;
            end else begin
                a_waitrequest = m_waitrequest;
            end
        end

        if (w_drive) begin
            case (r_state)
                S_IDLE, S_LOCK: begin
                    if ((m_read || m_write) && !m_waitrequest) begin
                        w_last_grant_next = w_sel;
                        if (m_read) begin
                            w_push       = 1'b1;
                            w_push_bc    = w_s_bc_eff;
                            w_state_next = S_IDLE;
                        end else if (w_s_bc_eff > 8'd1) begin
                            w_owner_next   = w_sel;
                            w_wr_left_next = w_s_bc_eff - 8'd1;
                            w_state_next   = S_WR_BURST;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else if (r_state == S_IDLE) begin
                        w_owner_next = w_sel;
                        w_state_next = S_LOCK;
                    end
                end
                S_WR_BURST: begin
                    if (m_write && !m_waitrequest) begin
                        w_wr_left_next = r_wr_left - 8'd1;
                        if (r_wr_left == 8'd1) begin
                            w_state_next = S_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Read return steering
    // -------------------------------------------------------------------------
    assign w_head_port = r_tag_port[r_rd_ptr];
    assign w_head_bc   = r_tag_bc[r_rd_ptr];
    // r_rd_left == 0 marks the first beat of the head burst
    assign w_rd_rem    = (r_rd_left == 8'd0) ? w_head_bc : r_rd_left;
    assign w_rv        = m_readdatavalid & ~w_fifo_empty & reset_n;
    assign w_pop       = w_rv & (w_rd_rem == 8'd1);

    assign a_readdata      = m_readdata;
    assign b_readdata      = m_readdata;
    assign a_readdatavalid = w_rv & (w_head_port == P_A);
    assign b_readdatavalid = w_rv & (w_head_port == P_B);
    assign rd_outstanding  = r_cnt;
    assign err_orphan      = r_err_orphan;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= P_B;
            r_owner      <= P_A;
            r_wr_left    <= 8'd0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_cnt        <= '0;
            r_rd_left    <= 8'd0;
            r_err_orphan <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_owner      <= w_owner_next;
            r_wr_left    <= w_wr_left_next;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase

            if (w_rv) begin
                r_rd_left <= w_pop ? 8'd0 : (w_rd_rem - 8'd1);
            end

            if (m_readdatavalid && w_fifo_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: an entry is only read once it was pushed.
    generate
        for (genvar gi = 0; gi < MAX_RD_OUTST; gi++) begin : g_tag
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == PW'(gi))) begin
                    r_tag_port[gi] <= w_sel;
                    r_tag_bc[gi]   <= w_push_bc;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
module tb_sdram_burst_arbiter;

    localparam int WA = 29;
    localparam int WD = 64;
    localparam int WB = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [WA-1:0] a_address, b_address;
    logic [7:0]    a_burstcount, b_burstcount;
    logic          a_read, a_write, b_read, b_write;
    logic [WD-1:0] a_writedata, b_writedata;
    logic [WB-1:0] a_byteenable, b_byteenable;
    logic          a_waitrequest, b_waitrequest;
    logic [WD-1:0] a_readdata, b_readdata;
    logic          a_readdatavalid, b_readdatavalid;
    logic [WA-1:0] m_address;
    logic [7:0]    m_burstcount;
    logic          m_read, m_write;
    logic [WD-1:0] m_writedata;
    logic [WB-1:0] m_byteenable;
    logic          m_waitrequest;
    logic [WD-1:0] m_readdata;
    logic          m_readdatavalid;
    logic [2:0]    rd_outstanding;
    logic          err_orphan;

    int checks = 0;
    int errors = 0;

    sdram_burst_arbiter #(
        .WIDTH_ADDR(WA), .WIDTH_DATA(WD), .WIDTH_BE(WB), .MAX_RD_OUTST(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .a_address(a_address), .a_burstcount(a_burstcount), .a_read(a_read),
        .a_write(a_write), .a_writedata(a_writedata), .a_byteenable(a_byteenable),
        .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
        .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_burstcount(b_burstcount), .b_read(b_read),
        .b_write(b_write), .b_writedata(b_writedata), .b_byteenable(b_byteenable),
        .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
        .b_readdatavalid(b_readdatavalid),
        .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read),
        .m_write(m_write), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid),
        .rd_outstanding(rd_outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // new cycle: inputs are driven 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle before sampling
    task automatic settle();
        #2;
    endtask

    initial begin
        reset_n = 1'b0;
        a_address = '0; a_burstcount = '0; a_read = 0; a_write = 0;
        a_writedata = '0; a_byteenable = '0;
        b_address = '0; b_burstcount = '0; b_read = 0; b_write = 0;
        b_writedata = '0; b_byteenable = '0;
        m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        settle();
        chk("rst_m_read", m_read, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_m_address", m_address, 0);
        chk("rst_a_wait", a_waitrequest, 1);
        chk("rst_b_wait", b_waitrequest, 1);
        chk("rst_rd_out", rd_outstanding, 0);
        chk("rst_err_orphan", err_orphan, 0);
        $display("txn reset checked");
        tick();
        reset_n = 1'b1;

        // ---------------- test 2: simultaneous write bursts ----------------
        tick();
        a_write = 1; a_burstcount = 8; a_address = 'h200; a_byteenable = 'hFF;
        b_write = 1; b_burstcount = 8; b_address = 'h300; b_byteenable = 'h0F;
        for (int k = 0; k < 8; k++) begin
            a_writedata = 64'hA000_0000_0000_0000 | 64'(k);
            b_writedata = 64'hB000_0000_0000_0000 | 64'(k);
            settle();
            if (k == 0) chk("wrA_addr", m_address, 'h200);
            chk("wrA_m_write", m_write, 1);
            chk("wrA_wdata", m_writedata, 64'hA000_0000_0000_0000 | 64'(k));
            chk("wrA_a_wait", a_waitrequest, 0);
            chk("wrA_b_wait", b_waitrequest, 1);
            tick();
        end
        a_write = 0;
        $display("txn A write burst 8 beats done");
        for (int k = 0; k < 8; k++) begin
            b_writedata = 64'hB000_0000_0000_0000 | 64'(k);
            settle();
            if (k == 0) begin
                chk("wrB_addr", m_address, 'h300);
                chk("wrB_bc", m_burstcount, 8);
            end
            chk("wrB_m_write", m_write, 1);
            chk("wrB_wdata", m_writedata, 64'hB000_0000_0000_0000 | 64'(k));
            chk("wrB_be", m_byteenable, 'h0F);
            chk("wrB_b_wait", b_waitrequest, 0);
            tick();
        end
        b_write = 0;
        settle();
        chk("wr_idle_m_write", m_write, 0);
        $display("txn B write burst 8 beats done");

        // ---------------- test 1: A read bc=4 ----------------
        tick();
        a_read = 1; a_burstcount = 4; a_address = 'h100;
        settle();
        chk("rdA_m_read", m_read, 1);
        chk("rdA_addr", m_address, 'h100);
        chk("rdA_bc", m_burstcount, 4);
        chk("rdA_a_wait", a_waitrequest, 0);
        tick();
        a_read = 0;
        settle();
        chk("rdA_out1", rd_outstanding, 1);
        chk("rdA_m_read_off", m_read, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            m_readdatavalid = 1; m_readdata = 64'hD0 + 64'(k);
            settle();
            chk("rdA_a_rdv", a_readdatavalid, 1);
            chk("rdA_b_rdv", b_readdatavalid, 0);
            chk("rdA_data", a_readdata, 64'hD0 + 64'(k));
        end
        tick();
        m_readdatavalid = 0;
        settle();
        chk("rdA_out0", rd_outstanding, 0);
        chk("rdA_rdv_off", a_readdatavalid, 0);
        $display("txn A read burst 4 beats returned");

        // ---------------- test 3: A bc=2 then B bc=3 ----------------
        tick();
        a_read = 1; a_burstcount = 2; a_address = 'h400;
        settle();
        chk("rd3A_addr", m_address, 'h400);
        tick();
        a_read = 0;
        b_read = 1; b_burstcount = 3; b_address = 'h500;
        settle();
        chk("rd3B_addr", m_address, 'h500);
        chk("rd3B_b_wait", b_waitrequest, 0);
        tick();
        b_read = 0;
        settle();
        chk("rd3_out2", rd_outstanding, 2);
        for (int k = 0; k < 5; k++) begin
            tick();
            m_readdatavalid = 1; m_readdata = 64'hE0 + 64'(k);
            settle();
            chk("rd3_a_rdv", a_readdatavalid, (k < 2) ? 1 : 0);
            chk("rd3_b_rdv", b_readdatavalid, (k >= 2) ? 1 : 0);
            if (k >= 2) chk("rd3_b_data", b_readdata, 64'hE0 + 64'(k));
        end
        tick();
        m_readdatavalid = 0;
        settle();
        chk("rd3_out0", rd_outstanding, 0);
        $display("txn A bc2 + B bc3 returns done");

        // ---------------- test 4: fifo full ----------------
        for (int i = 0; i < 4; i++) begin
            tick();
            a_read = 1; a_burstcount = 2; a_address = WA'('h600 + i);
            settle();
            chk("full_issue_wait", a_waitrequest, 0);
        end
        tick();
        a_address = 'h604;
        m_readdatavalid = 1; m_readdata = 64'h11;
        settle();
        chk("full_out4", rd_outstanding, 4);
        chk("full_a_wait", a_waitrequest, 1);
        chk("full_m_read", m_read, 0);
        chk("full_rdv0", a_readdatavalid, 1);
        tick();
        settle();
        chk("full_rdv1", a_readdatavalid, 1);
        chk("full_pop_no_unblock", a_waitrequest, 1);
        tick();
        m_readdatavalid = 0;
        settle();
        chk("full_out3", rd_outstanding, 3);
        chk("full_5th_wait", a_waitrequest, 0);
        chk("full_5th_addr", m_address, 'h604);
        tick();
        a_read = 0;
        settle();
        chk("full_out4b", rd_outstanding, 4);
        for (int j = 0; j < 8; j++) begin
            tick();
            m_readdatavalid = 1;
            settle();
            chk("full_drain_rdv", a_readdatavalid, 1);
        end
        tick();
        m_readdatavalid = 0;
        settle();
        chk("full_drain_out0", rd_outstanding, 0);
        $display("txn fifo full stall and drain done");

        // ---------------- test 5: master stall holds A ----------------
        tick();
        m_waitrequest = 1;
        a_write = 1; a_burstcount = 1; a_address = 'h700; a_writedata = 64'h77;
        settle();
        chk("stall_addr0", m_address, 'h700);
        chk("stall_a_wait0", a_waitrequest, 1);
        tick();
        b_write = 1; b_burstcount = 1; b_address = 'h800; b_writedata = 64'h88;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("stall_addr", m_address, 'h700);
            chk("stall_wdata", m_writedata, 64'h77);
            chk("stall_b_wait", b_waitrequest, 1);
            tick();
        end
        m_waitrequest = 0;
        settle();
        chk("stall_accept_a_wait", a_waitrequest, 0);
        chk("stall_accept_addr", m_address, 'h700);
        tick();
        a_write = 0;
        settle();
        chk("stall_B_addr", m_address, 'h800);
        chk("stall_B_wait", b_waitrequest, 0);
        chk("stall_A_wait", a_waitrequest, 1);
        tick();
        b_write = 0;
        $display("txn stalled A then B done");

        // ---------------- test 6: reset mid burst, orphan beat ----------------
        tick();
        a_write = 1; a_burstcount = 8; a_address = 'h900; a_writedata = 64'h99;
        tick();
        tick();
        settle();
        chk("rst6_beat3_write", m_write, 1);
        tick();
        reset_n = 0; a_write = 0;
        settle();
        chk("rst6_m_write", m_write, 0);
        chk("rst6_m_address", m_address, 0);
        chk("rst6_a_wait", a_waitrequest, 1);
        tick();
        reset_n = 1;
        settle();
        chk("rst6_idle_write", m_write, 0);
        chk("rst6_err0", err_orphan, 0);
        tick();
        m_readdatavalid = 1; m_readdata = 64'h55;
        settle();
        chk("orphan_a_rdv", a_readdatavalid, 0);
        chk("orphan_b_rdv", b_readdatavalid, 0);
        tick();
        m_readdatavalid = 0;
        settle();
        chk("orphan_err", err_orphan, 1);
        chk("orphan_out", rd_outstanding, 0);
        $display("txn reset mid burst and orphan beat done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
